// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the scratchComputer pipeline sequencer:
// state encoding, strobe decode and default memory-wait timeout.
package pipeline_sequencer_pkg;

  localparam int unsigned SEQ_STATE_WIDTH     = 3;
  localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;
  localparam int unsigned NUM_STROBES         = 7;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    ST_HALTED  = 3'd0,
    ST_FREQ    = 3'd1,
    ST_FRECV   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_SETUP   = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_MEMRD   = 3'd6,
    ST_WB      = 3'd7
  } seq_state_e;

  // One-hot strobe vector, MSB first:
  // {fetch_Request, fetch_Receive, decode, setup, execute, memRead, writeback}
  function automatic logic [NUM_STROBES-1:0] state_strobes(input seq_state_e s);
    logic [NUM_STROBES-1:0] v;
    v = '0;
    case (s)
      ST_FREQ:    v = 7'b1000000;
      ST_FRECV:   v = 7'b0100000;
      ST_DECODE:  v = 7'b0010000;
      ST_SETUP:   v = 7'b0001000;
      ST_EXECUTE: v = 7'b0000100;
      ST_MEMRD:   v = 7'b0000010;
      ST_WB:      v = 7'b0000001;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_mem_wait_timer.sv
// Clearable saturating wait counter; expired_o marks the last allowed
// wait cycle (the MEM_TIMEOUT-th cycle spent in the current state).
module mem_wait_timer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Count cycles held in the current state, restart on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_q != LIMIT) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/pipeline_sequencer.sv
// Multi-cycle control sequencer: one-hot stage strobes, memory wait
// handshakes with timeout, halt control, retire and stall counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_in,
  input  logic                  halt_in,
  input  logic                  instrGrant_in,
  input  logic                  instrValid_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic                  dataValid_in,
  output logic                  instrReq_out,
  output logic                  fetch_RequestState,
  output logic                  fetch_ReceiveState,
  output logic                  decodeState,
  output logic                  setupState,
  output logic                  executeState,
  output logic                  memReadState,
  output logic                  writebackState,
  output logic                  halted_out,
  output logic                  memFault_out,
  output logic [DATA_WIDTH-1:0] retiredCount_out,
  output logic [DATA_WIDTH-1:0] stallCount_out
);

  seq_state_e             state_q, state_d;
  logic [NUM_STROBES-1:0] strobes_q;
  logic                   halted_q;
  logic                   fault_q, fault_d;
  logic                   pend_q, pend_d;
  logic [DATA_WIDTH-1:0]  retired_q;
  logic [DATA_WIDTH-1:0]  stall_q;
  logic                   retire_inc;
  logic                   stall_inc;
  logic                   expired;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .expired_o (expired)
  );

  // Next-state, fault, halt-request and counter-increment decisions.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    retire_inc = 1'b0;
    stall_inc  = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (run_in && !halt_in && !fault_q) state_d = ST_FREQ;
      end
      ST_FREQ: begin
        if (instrGrant_in) state_d = ST_FRECV;
        else begin
          stall_inc = 1'b1;
          if (expired) begin
            state_d = ST_HALTED;
            fault_d = 1'b1;
          end
        end
      end
      ST_FRECV: begin
        if (instrValid_in) state_d = ST_DECODE;
        else begin
          stall_inc = 1'b1;
          if (expired) begin
            state_d = ST_HALTED;
            fault_d = 1'b1;
          end
        end
      end
      ST_DECODE:  state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (load_in || store_in) ? ST_MEMRD : ST_WB;
      ST_MEMRD: begin
        if (dataValid_in) state_d = ST_WB;
        else begin
          stall_inc = 1'b1;
          if (expired) begin
            state_d = ST_HALTED;
            fault_d = 1'b1;
          end
        end
      end
      ST_WB: begin
        retire_inc = 1'b1;
        state_d    = (halt_in || pend_q) ? ST_HALTED : ST_FREQ;
      end
      default: state_d = ST_HALTED;
    endcase
    // A halt raised mid-instruction is remembered until the WB exit.
    if (state_d == ST_HALTED) pend_d = 1'b0;
    else                      pend_d = pend_q || (halt_in && (state_q != ST_HALTED));
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HALTED;
      strobes_q <= '0;
      halted_q  <= 1'b1;
      fault_q   <= 1'b0;
      pend_q    <= 1'b0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      strobes_q <= state_strobes(state_d);
      halted_q  <= (state_d == ST_HALTED);
      fault_q   <= fault_d;
      pend_q    <= pend_d;
      if (retire_inc) retired_q <= retired_q + 1'b1;
      if (stall_inc)  stall_q   <= stall_q + 1'b1;
    end
  end

  assign {fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
          executeState, memReadState, writebackState} = strobes_q;
  assign instrReq_out     = strobes_q[6];
  assign halted_out       = halted_q;
  assign memFault_out     = fault_q;
  assign retiredCount_out = retired_q;
  assign stallCount_out   = stall_q;

endmodule
